// File: rtl/rgmii_transmit_sequencer.sv
// RGMII transmit framing: preamble/SFD insertion, payload pass-through with
// underrun/oversize error signalling, and inter-frame gap enforcement.
module rgmii_transmit_sequencer #(
  parameter int unsigned PREAMBLE_LENGTH  = 7,
  parameter int unsigned IFG_LENGTH       = 12,
  parameter int unsigned MAX_FRAME_LENGTH = 1522
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd_ddr,
  output logic [1:0] tx_ctl_ddr,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_error
);

  localparam logic [3:0]  PRE_LEN  = 4'(PREAMBLE_LENGTH);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_LENGTH - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_LENGTH);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, IFG} state_t;

  state_t      state, state_next;
  logic [3:0]  pre_cnt, pre_cnt_next;
  logic [7:0]  ifg_cnt, ifg_cnt_next;
  logic [15:0] byte_cnt, byte_cnt_next, byte_inc;
  logic        err_latch, err_next;
  logic        oversize;
  logic [7:0]  tx_byte;
  logic        tx_en, tx_er;
  logic        done_next, ferr_next;

  assign s_ready  = (state == PAYLOAD);
  assign busy     = (state != IDLE);
  assign byte_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign oversize = (byte_inc > MAX_LEN);

  // Each state decides what goes on the wire in the following cycle, so the
  // state register runs one step ahead of the registered outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next    = state;
    pre_cnt_next  = pre_cnt;
    ifg_cnt_next  = ifg_cnt;
    byte_cnt_next = byte_cnt;
    err_next      = err_latch;
    tx_byte       = 8'h00;
    tx_en         = 1'b0;
    tx_er         = 1'b0;
    done_next     = 1'b0;
    ferr_next     = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_valid) begin
          state_next   = (PRE_LEN == 4'd1) ? SFD : PREAMBLE;
          pre_cnt_next = 4'd1;
          tx_byte      = 8'h55;
          tx_en        = 1'b1;
        end
      end
      PREAMBLE: begin
        tx_byte      = 8'h55;
        tx_en        = 1'b1;
        pre_cnt_next = pre_cnt + 4'd1;
        if (pre_cnt + 4'd1 == PRE_LEN) state_next = SFD;
      end
      SFD: begin
        tx_byte       = 8'hD5;
        tx_en         = 1'b1;
        byte_cnt_next = 16'd0;
        err_next      = 1'b0;
        state_next    = PAYLOAD;
      end
      PAYLOAD: begin
        tx_en = 1'b1;
        if (s_valid) begin
          tx_byte       = s_data;
          byte_cnt_next = byte_inc;
          if (oversize) begin
            tx_er    = 1'b1;
            err_next = 1'b1;
          end
          if (s_last) begin
            done_next     = 1'b1;
            ferr_next     = err_latch | oversize;
            err_next      = 1'b0;
            byte_cnt_next = 16'd0;
            ifg_cnt_next  = 8'd0;
            state_next    = IFG;
          end
        end else begin
          // Underrun: keep TX_EN up and mark the filler byte as errored.
          tx_er    = 1'b1;
          err_next = 1'b1;
        end
      end
      IFG: begin
        ifg_cnt_next = ifg_cnt + 8'd1;
        if (ifg_cnt == IFG_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state       <= IDLE;
      pre_cnt     <= 4'd0;
      ifg_cnt     <= 8'd0;
      byte_cnt    <= 16'd0;
      err_latch   <= 1'b0;
      txd_ddr     <= 8'h00;
      tx_ctl_ddr  <= 2'b00;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      pre_cnt     <= pre_cnt_next;
      ifg_cnt     <= ifg_cnt_next;
      byte_cnt    <= byte_cnt_next;
      err_latch   <= err_next;
      txd_ddr     <= {tx_byte[3:0], tx_byte[7:4]};
      tx_ctl_ddr  <= {tx_en, tx_en ^ tx_er};
      frame_done  <= done_next;
      frame_error <= ferr_next;
    end
  end

endmodule

// File: tb/tb_rgmii_transmit_sequencer.sv
// Scoreboard bench for rgmii_transmit_sequencer: the driver queues the expected
// wire words, a negedge monitor pops and compares whenever TX_EN is high.
module tb_rgmii_transmit_sequencer;

  localparam int MAX_LEN = 64;

  typedef struct packed {
    logic [7:0] txd;
    logic [1:0] ctl;
    logic       done;
    logic       ferr;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] txd_ddr;
  logic [1:0] tx_ctl_ddr;
  logic       busy;
  logic       frame_done;
  logic       frame_error;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];

  int   exp_start = -1;
  logic b2b_check = 1'b0;
  int   done_cyc = 0;
  logic have_done = 1'b0;
  logic in_gap = 1'b0;
  logic ready_in_gap = 1'b0;
  logic prev_en = 1'b0;
  logic prev_done = 1'b0;
  logic prev_reset = 1'b1;

  rgmii_transmit_sequencer #(
    .PREAMBLE_LENGTH (7),
    .IFG_LENGTH      (12),
    .MAX_FRAME_LENGTH(MAX_LEN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .txd_ddr    (txd_ddr),
    .tx_ctl_ddr (tx_ctl_ddr),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives frame_q, queueing preamble, SFD (byte 0xD5, nibble-swapped on the
  // wire), payload and underrun filler words in wire order.
  task automatic send_frame(input int gap_after, input int gap_len, input int abort_after);
    int         n;
    int         i;
    int         gap;
    int         budget;
    logic       ferr;
    logic [7:0] b;
    exp_t       e;
    n = frame_q.size();
    i = 0;
    gap = gap_len;
    budget = 0;
    ferr = 1'b0;
    for (int k = 0; k < 7; k++) exp_q.push_back('{8'h55, 2'b11, 1'b0, 1'b0});
    exp_q.push_back('{8'h5D, 2'b11, 1'b0, 1'b0});
    while (i < n) begin
      s_valid = !(i == gap_after && gap > 0);
      b = frame_q[i];
      s_data = b;
      s_last = (i == n - 1);
      if (s_ready) begin
        if (s_valid) begin
          e.txd = {b[3:0], b[7:4]};
          e.ctl = (i + 1 > MAX_LEN) ? 2'b10 : 2'b11;
          ferr = ferr | (i + 1 > MAX_LEN);
          e.done = (i == n - 1);
          e.ferr = (i == n - 1) && ferr;
          i++;
        end else begin
          e = '{8'h00, 2'b10, 1'b0, 1'b0};
          ferr = 1'b1;
          gap--;
        end
        exp_q.push_back(e);
      end
      @(posedge clock); #1;
      budget++;
      if (i == abort_after) break;
      if (budget > n + 100) begin
        check("handshake timeout s_ready", {31'd0, s_ready}, 32'd1);
        break;
      end
    end
    if (abort_after < 0) begin
      s_valid = 1'b0;
      s_last = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic en;
    en = (tx_ctl_ddr[1] === 1'b1);
    if (en) begin
      if (!prev_en) begin
        in_gap = 1'b0;
        if (exp_start >= 0) begin
          check("start latency", cyc, exp_start);
          exp_start = -1;
        end
        if (b2b_check && have_done) begin
          check("back-to-back gap", cyc - done_cyc, 13);
          check("s_ready during ifg", {31'd0, ready_in_gap}, 32'd0);
          b2b_check = 1'b0;
        end
      end
      if (exp_q.size() == 0) begin
        check("unexpected tx word", {30'd0, tx_ctl_ddr}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx word", {20'd0, txd_ddr, tx_ctl_ddr, frame_done, frame_error}, {20'd0, e});
      end
      if (frame_done === 1'b1) begin
        done_cyc = cyc;
        have_done = 1'b1;
        in_gap = 1'b1;
        ready_in_gap = 1'b0;
      end
    end else begin
      if (prev_en && !prev_done && !prev_reset)
        check("tx_en dropped mid-frame", {31'd0, prev_done}, 32'd1);
      if (frame_done === 1'b1)
        check("frame_done without tx_en", {31'd0, frame_done}, 32'd0);
    end
    if (in_gap && s_ready === 1'b1) ready_in_gap = 1'b1;
    if (reset) begin
      have_done = 1'b0;
      in_gap = 1'b0;
    end
    prev_en = en;
    prev_done = (frame_done === 1'b1);
    prev_reset = reset;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset txd_ddr", {24'd0, txd_ddr}, 32'd0);
    check("reset tx_ctl_ddr", {30'd0, tx_ctl_ddr}, 32'd0);
    check("reset s_ready", {31'd0, s_ready}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    check("reset frame_error", {31'd0, frame_error}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // 4-byte frame, first 0x55 exactly one cycle after s_valid rises.
    exp_start = cyc + 1;
    frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(-1, 0, -1);
    // Back-to-back: s_valid held from the IFG onward.
    b2b_check = 1'b1;
    frame_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(-1, 0, -1);
    repeat (20) @(posedge clock);
    #1;
    check("b2b gap measured", {31'd0, b2b_check}, 32'd0);

    // Underrun: two idle cycles after byte 2 of a 6-byte frame.
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(2, 2, -1);
    repeat (15) @(posedge clock);
    #1;

    // Oversize 66-byte frame, then a clean 64-byte frame.
    frame_q.delete();
    for (int k = 0; k < 66; k++) frame_q.push_back(8'(k * 7 + 3));
    send_frame(-1, 0, -1);
    repeat (15) @(posedge clock);
    #1;
    frame_q.delete();
    for (int k = 0; k < 64; k++) frame_q.push_back(8'(255 - k));
    send_frame(-1, 0, -1);
    repeat (15) @(posedge clock);
    #1;

    // Reset while byte 3 is on the wire.
    frame_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_frame(-1, 0, 3);
    reset = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    @(posedge clock);
    #1;
    check("abort txd_ddr", {24'd0, txd_ddr}, 32'd0);
    check("abort tx_ctl_ddr", {30'd0, tx_ctl_ddr}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort frame_done", {31'd0, frame_done}, 32'd0);
    check("abort frame_error", {31'd0, frame_error}, 32'd0);
    check("abort pending words", exp_q.size(), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Single-byte frame after reset: full preamble, 0xA5 on wire as 0x5A.
    exp_start = cyc + 1;
    frame_q = '{8'hA5};
    send_frame(-1, 0, -1);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clock);
    repeat (14) @(posedge clock);
    #1;
    check("scoreboard drained", exp_q.size(), 32'd0);
    check("idle after ifg busy", {31'd0, busy}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
